// File: rtl/mdio_master.sv
// MDIO (clause 22) management frame master. Serialises one read or write
// frame per accepted start, one MDIO bit per clk cycle.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   data                MDIO line, driven or released (external pull-up)
//   start               frame request, honoured only while busy=0
//   cmd_read            1 = read frame (OP=10), 0 = write frame (OP=01)
//   phy_addr, reg_addr  5-bit addresses, sent MSB first
//   wr_data             16-bit write payload, sent MSB first
//   busy                frame in progress
//   done                one-cycle pulse at frame completion
//   rd_data, rd_err     payload and turnaround error of the last read
module mdio_master #(
  parameter int PREAMBLE_LEN = 32
) (
  input  logic        clk,
  input  logic        reset,
  inout  wire         data,
  input  logic        start,
  input  logic        cmd_read,
  input  logic [4:0]  phy_addr,
  input  logic [4:0]  reg_addr,
  input  logic [15:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        rd_err
);

  localparam int unsigned CNT_W = 5;

  typedef enum logic [2:0] {
    IDLE, PRE, ST, OP, PHYAD, REGAD, TA, DATA
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               oe;
  logic               dout;
  logic               rd_q;
  logic [4:0]         phy_q;
  logic [4:0]         reg_q;
  logic [15:0]        wr_q;
  logic [14:0]        rd_shift;
  logic               ta_err;

  assign data = oe ? dout : 1'bz;

  // State/cnt name the bit currently on the line; each edge loads the next bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      oe       <= 1'b0;
      dout     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_data  <= '0;
      rd_err   <= 1'b0;
      rd_q     <= 1'b0;
      phy_q    <= '0;
      reg_q    <= '0;
      wr_q     <= '0;
      rd_shift <= '0;
      ta_err   <= 1'b0;
    end else begin
      done <= 1'b0;
      cnt  <= cnt + CNT_W'(1);
      case (state)
        IDLE: begin
          oe  <= 1'b0;
          cnt <= '0;
          if (start) begin
            rd_q  <= cmd_read;
            phy_q <= phy_addr;
            reg_q <= reg_addr;
            wr_q  <= wr_data;
            busy  <= 1'b1;
            oe    <= 1'b1;
            if (PREAMBLE_LEN > 0) begin
              state <= PRE;
              dout  <= 1'b1;
            end else begin
              state <= ST;
              dout  <= 1'b0;
            end
          end
        end
        PRE: begin
          if (cnt == CNT_W'(PREAMBLE_LEN - 1)) begin
            state <= ST;
            cnt   <= '0;
            dout  <= 1'b0;
          end else begin
            dout <= 1'b1;
          end
        end
        ST: begin
          if (cnt == '0) begin
            dout <= 1'b1;
          end else begin
            state <= OP;
            cnt   <= '0;
            dout  <= rd_q;
          end
        end
        OP: begin
          if (cnt == '0) begin
            dout <= ~rd_q;
          end else begin
            state <= PHYAD;
            cnt   <= '0;
            dout  <= phy_q[4];
          end
        end
        PHYAD: begin
          if (cnt == CNT_W'(4)) begin
            state <= REGAD;
            cnt   <= '0;
            dout  <= reg_q[4];
          end else begin
            dout <= phy_q[3'(3 - cnt)];
          end
        end
        REGAD: begin
          if (cnt == CNT_W'(4)) begin
            // Reads hand the line to the PHY from the first TA bit onward.
            state <= TA;
            cnt   <= '0;
            oe    <= ~rd_q;
            dout  <= 1'b1;
          end else begin
            dout <= reg_q[3'(3 - cnt)];
          end
        end
        TA: begin
          if (cnt == '0) begin
            dout <= 1'b0;
          end else begin
            state <= DATA;
            cnt   <= '0;
            dout  <= wr_q[15];
            // Anything but a clean 0 (including X/Z) is a turnaround error.
            if (rd_q) begin
              if (data == 1'b0) ta_err <= 1'b0;
              else              ta_err <= 1'b1;
            end
          end
        end
        DATA: begin
          if (rd_q) rd_shift <= {rd_shift[13:0], data};
          if (cnt == CNT_W'(15)) begin
            state <= IDLE;
            cnt   <= '0;
            oe    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            if (rd_q) begin
              rd_data <= {rd_shift, data};
              rd_err  <= ta_err;
            end
          end else begin
            dout <= wr_q[4'(14 - cnt)];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_master.sv
// Directed bench for mdio_master: write/read frames, missing PHY, back-to-back
// frames with start held high, reset mid-frame, and a zero-preamble instance.
module tb_mdio_master;

  localparam int P = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        start0 = 1'b0;
  logic        cmd_read = 1'b0;
  logic [4:0]  phy_addr = '0;
  logic [4:0]  reg_addr = '0;
  logic [15:0] wr_data = '0;
  logic        busy, done, rd_err;
  logic        busy0, done0, rd_err0;
  logic [15:0] rd_data, rd_data0;
  logic        phy_oe = 1'b0;
  logic        phy_val = 1'b0;

  wire mdio;
  wire mdio0;
  pullup (mdio);
  pullup (mdio0);
  assign mdio = phy_oe ? phy_val : 1'bz;

  int n_checks = 0;
  int n_pass = 0;

  logic [63:0] cap;
  int          busy_n;
  int          done_n;

  always #5 clk = ~clk;

  mdio_master #(.PREAMBLE_LEN(32)) dut (
    .clk(clk), .reset(reset), .data(mdio), .start(start),
    .cmd_read(cmd_read), .phy_addr(phy_addr), .reg_addr(reg_addr),
    .wr_data(wr_data), .busy(busy), .done(done), .rd_data(rd_data),
    .rd_err(rd_err)
  );

  mdio_master #(.PREAMBLE_LEN(0)) dut0 (
    .clk(clk), .reset(reset), .data(mdio0), .start(start0),
    .cmd_read(cmd_read), .phy_addr(phy_addr), .reg_addr(reg_addr),
    .wr_data(wr_data), .busy(busy0), .done(done0), .rd_data(rd_data0),
    .rd_err(rd_err0)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Called at the negedge before E0; returns at the negedge after E0 with
  // the inputs scrambled so the frame must come from the latched copies.
  task automatic issue(input logic rd, input logic [4:0] pa, input logic [4:0] ra,
                       input logic [15:0] wd);
    cmd_read = rd;
    phy_addr = pa;
    reg_addr = ra;
    wr_data  = wd;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    cmd_read = ~rd;
    phy_addr = ~pa;
    reg_addr = ~ra;
    wr_data  = ~wd;
  endtask

  // Samples n line bits of the main instance, acting as PHY on reads.
  task automatic capture(input int n, input logic rd, input logic resp_en,
                         input logic [15:0] resp, input logic poke,
                         output logic [63:0] c, output int b_n, output int d_n);
    c = '0;
    b_n = 0;
    d_n = 0;
    for (int k = 1; k <= n; k++) begin
      if (rd && resp_en && k == P + 16) begin
        phy_oe = 1'b1;
        phy_val = 1'b0;
      end else if (rd && resp_en && k >= P + 17 && k <= P + 32) begin
        phy_oe = 1'b1;
        phy_val = resp[4'(P + 32 - k)];
      end else begin
        phy_oe = 1'b0;
      end
      if (poke) start = k[0];
      #1;
      c = {c[62:0], mdio};
      if (busy) b_n++;
      if (done) d_n++;
      @(negedge clk);
    end
    phy_oe = 1'b0;
    if (poke) start = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_rd_data", 64'(rd_data), 64'(0));
    check("rst_rd_err", 64'(rd_err), 64'(0));
    check("rst_line", 64'(mdio), 64'(1));
    reset = 1'b0;
    @(negedge clk);

    // Write frame, 32-bit preamble
    issue(1'b0, 5'h01, 5'h02, 16'hA5C3);
    check("wr_busy_e0", 64'(busy), 64'(1));
    capture(64, 1'b0, 1'b0, 16'h0, 1'b0, cap, busy_n, done_n);
    check("wr_frame", cap, {32'hFFFF_FFFF, 2'b01, 2'b01, 5'h01, 5'h02, 2'b10, 16'hA5C3});
    check("wr_busy_cycles", 64'(busy_n), 64'(64));
    check("wr_no_early_done", 64'(done_n), 64'(0));
    check("wr_end", 64'({busy, done}), 64'(2'b01));
    check("wr_rd_untouched", 64'({rd_err, rd_data}), 64'(0));
    @(negedge clk);
    check("wr_done_one_cycle", 64'(done), 64'(0));

    // Read with PHY response
    issue(1'b1, 5'h1F, 5'h00, 16'h0);
    capture(64, 1'b1, 1'b1, 16'h1234, 1'b0, cap, busy_n, done_n);
    check("rd_frame", cap, {32'hFFFF_FFFF, 2'b01, 2'b10, 5'h1F, 5'h00, 2'b10, 16'h1234});
    check("rd_end", 64'({busy, done}), 64'(2'b01));
    check("rd_data", 64'(rd_data), 64'(16'h1234));
    check("rd_err_clean", 64'(rd_err), 64'(0));
    @(negedge clk);

    // Read with no PHY, start toggled while busy
    issue(1'b1, 5'h0A, 5'h11, 16'h0);
    capture(64, 1'b1, 1'b0, 16'h0, 1'b1, cap, busy_n, done_n);
    check("nophy_frame", cap, {32'hFFFF_FFFF, 2'b01, 2'b10, 5'h0A, 5'h11, 2'b11, 16'hFFFF});
    check("nophy_busy_cycles", 64'(busy_n), 64'(64));
    check("nophy_end", 64'({busy, done}), 64'(2'b01));
    check("nophy_rd_data", 64'(rd_data), 64'(16'hFFFF));
    check("nophy_rd_err", 64'(rd_err), 64'(1));
    @(negedge clk);
    check("nophy_no_queue", 64'(busy), 64'(0));

    // start held high: write then read with no gap
    cmd_read = 1'b0;
    phy_addr = 5'h12;
    reg_addr = 5'h1C;
    wr_data  = 16'h0F0F;
    start    = 1'b1;
    @(negedge clk);
    cmd_read = 1'b1;
    phy_addr = 5'h00;
    reg_addr = 5'h00;
    wr_data  = 16'hFFFF;
    capture(64, 1'b0, 1'b0, 16'h0, 1'b0, cap, busy_n, done_n);
    check("b2b_wr_frame", cap, {32'hFFFF_FFFF, 2'b01, 2'b01, 5'h12, 5'h1C, 2'b10, 16'h0F0F});
    check("b2b_wr_end", 64'({busy, done}), 64'(2'b01));
    check("b2b_wr_keeps_rd", 64'({rd_err, rd_data}), 64'({1'b1, 16'hFFFF}));
    cmd_read = 1'b1;
    phy_addr = 5'h03;
    reg_addr = 5'h04;
    @(negedge clk);
    start = 1'b0;
    check("b2b_rd_started", 64'({busy, done}), 64'(2'b10));
    capture(64, 1'b1, 1'b1, 16'h8001, 1'b0, cap, busy_n, done_n);
    check("b2b_rd_frame", cap, {32'hFFFF_FFFF, 2'b01, 2'b10, 5'h03, 5'h04, 2'b10, 16'h8001});
    check("b2b_rd_data", 64'({rd_err, rd_data}), 64'({1'b0, 16'h8001}));
    @(negedge clk);

    // Reset during bit 40 of a write (bit 41 would be phy[0] = 0)
    issue(1'b0, 5'h06, 5'h09, 16'hFFFF);
    capture(39, 1'b0, 1'b0, 16'h0, 1'b0, cap, busy_n, done_n);
    check("abort_prefix", cap, 64'({32'hFFFF_FFFF, 2'b01, 2'b01, 3'b001}));
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check("abort_state", 64'({busy, done}), 64'(2'b00));
    check("abort_line_released", 64'(mdio), 64'(1));
    reset = 1'b0;
    start = 1'b0;
    done_n = 0;
    for (int i = 0; i < 4; i++) begin
      if (done || busy) done_n++;
      @(negedge clk);
    end
    check("abort_quiet", 64'(done_n), 64'(0));
    issue(1'b0, 5'h15, 5'h0A, 16'h5A3C);
    capture(64, 1'b0, 1'b0, 16'h0, 1'b0, cap, busy_n, done_n);
    check("post_reset_frame", cap, {32'hFFFF_FFFF, 2'b01, 2'b01, 5'h15, 5'h0A, 2'b10, 16'h5A3C});
    check("post_reset_end", 64'({busy, done}), 64'(2'b01));
    @(negedge clk);

    // Zero-preamble instance
    cmd_read = 1'b0;
    phy_addr = 5'h0B;
    reg_addr = 5'h16;
    wr_data  = 16'hC0DE;
    start0   = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    cap = '0;
    busy_n = 0;
    done_n = 0;
    for (int k = 1; k <= 32; k++) begin
      #1;
      cap = {cap[62:0], mdio0};
      if (busy0) busy_n++;
      if (done0) done_n++;
      @(negedge clk);
    end
    check("p0_frame", cap, 64'({2'b01, 2'b01, 5'h0B, 5'h16, 2'b10, 16'hC0DE}));
    check("p0_busy_cycles", 64'(busy_n), 64'(32));
    check("p0_end", 64'({busy0, done0, done_n[0]}), 64'(3'b010));
    @(negedge clk);
    check("p0_done_one_cycle", 64'(done0), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mdio_master.md
MDIO_MASTER -- requirements
Module: mdio_master

Interface
REQ-001 Parameter PREAMBLE_LEN, default 32, number of preamble '1' bits sent before ST; legal range 0..32.
REQ-002 clk  input  1  bit clock; all logic on rising edge; one MDIO bit period per clk cycle.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 data  inout  1  MDIO serial line; driven or released (1'bz); idle level supplied by an external pull-up.
REQ-005 start  input  1  command request; accepted only when busy=0.
REQ-006 cmd_read  input  1  1 = read frame (OP=10), 0 = write frame (OP=01).
REQ-007 phy_addr  input  5  PHY address, sent MSB first.
REQ-008 reg_addr  input  5  register address, sent MSB first.
REQ-009 wr_data  input  16  write payload, sent MSB first.
REQ-010 busy  output  1  frame in progress.
REQ-011 done  output  1  one-cycle pulse at frame completion.
REQ-012 rd_data  output  16  last read payload.
REQ-013 rd_err  output  1  last read had a bad turnaround (TA bit 2 sampled as not 0).

Function
REQ-014 States: IDLE, PRE, ST, OP, PHYAD, REGAD, TA, DATA; one bit counter, width >= 5.
REQ-015 In IDLE data is released; start=1 at edge E0 latches cmd_read, phy_addr, reg_addr, wr_data and sets busy=1 from E0.
REQ-016 Inputs other than start are don't-care after E0; the latched copies are used for the whole frame.
REQ-017 Bit k of the frame (k=1..N) is on data during the cycle after edge E(k-1); drive enable and drive value are registered.
REQ-018 Frame order: PREAMBLE_LEN x '1', ST '01', OP, PHYAD[4:0], REGAD[4:0], TA, DATA[15:0]; PREAMBLE_LEN=0 skips PRE.
REQ-019 Write: TA driven '10', DATA driven from wr_data; N = PREAMBLE_LEN+32 bits.
REQ-020 Read: data released for both TA bits and all 16 DATA bits; N = PREAMBLE_LEN+32.
REQ-021 Read: data sampled at the edge ending TA bit 2; a value other than 0 (including Z or X) sets internal error flag.
REQ-022 Read: data sampled at the edge ending each DATA bit and shifted in MSB first.
REQ-023 At edge E(N): busy=0, done=1 for exactly one cycle, data released; on reads, rd_data and rd_err update at E(N).
REQ-024 Write frames leave rd_data and rd_err unchanged.
REQ-025 start while busy=1 is ignored; no queuing.
REQ-026 start in the done cycle (busy=0) is accepted; back-to-back frames have no idle gap.
REQ-027 The read frame completes in full even when rd_err is set; no abort.

Reset
REQ-028 reset=1 at any edge forces IDLE: busy=0, done=0, rd_data=0, rd_err=0, data released from the following cycle, counters cleared.
REQ-029 Reset mid-frame aborts without a done pulse; start coinciding with reset is ignored.

Verification
REQ-030 Write, PREAMBLE_LEN=32, phy=5'h01, reg=5'h02, wr_data=16'hA5C3 -> data carries 32x1,01,01,00001,00010,10,1010010111000011; done at E64; busy high E0..E63.
REQ-031 Read, phy=5'h1F, reg=5'h00, bench PHY drives TA bit 2 as 0 then 16'h1234 -> data released from TA; rd_data=16'h1234, rd_err=0 at E64.
REQ-032 Read with no PHY response (pull-up only) -> rd_data=16'hFFFF, rd_err=1, done at E64.
REQ-033 start held high through two frames (write then read) -> second frame starts at the done edge; start pulses during busy have no effect.
REQ-034 reset asserted at bit 40 of a write -> busy=0 next cycle, data=Z, no done pulse; a new write after reset is bit-exact.
REQ-035 PREAMBLE_LEN=0 write -> first bit on data is ST '0'; done at E32.
